// File: rtl/grf_multiport.sv
// rtl/grf_multiport.sv - multi-read, dual-write general register file with busy scoreboard
module grf_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rbusy,
    input  logic                       issue_valid,
    input  logic [ADDR_W-1:0]          issue_addr,
    output logic                       busy_any
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic              wr0_ok;
    logic              wr1_ok;
    logic              issue_ok;

    // Register 0 is hardwired when ZERO_REG is set, so it is never written or marked busy.
    always_comb begin
        wr0_ok   = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
        wr1_ok   = we1 && !((ZERO_REG != 0) && (waddr1 == '0));
        issue_ok = issue_valid && !((ZERO_REG != 0) && (issue_addr == '0));
    end

    // Writeback clears first, then a new issue sets: a fresh producer wins over retirement.
    always_comb begin
        busy_next = busy;
        if (we0) busy_next[waddr0] = 1'b0;
        if (we1) busy_next[waddr1] = 1'b0;
        if (issue_ok) busy_next[issue_addr] = 1'b1;
    end

    // Port 1 is written last so the younger instruction wins an address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr0_ok) regs[waddr0] <= wdata0;
            if (wr1_ok) regs[waddr1] <= wdata1;
            busy <= busy_next;
        end
    end

    assign busy_any = |busy;

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] rd_addr;
            logic              hit0;
            logic              hit1;
            logic [DATA_W-1:0] rd_val;

            assign rd_addr = raddr[k*ADDR_W +: ADDR_W];

            // Forwarding is suppressed during reset so reads stay zero while it is held.
            always_comb begin
                hit0   = (BYPASS != 0) && !reset && wr0_ok && (waddr0 == rd_addr);
                hit1   = (BYPASS != 0) && !reset && wr1_ok && (waddr1 == rd_addr);
                rd_val = regs[rd_addr];
                if (hit1) begin
                    rd_val = wdata1;
                end else if (hit0) begin
                    rd_val = wdata0;
                end
            end

            assign rdata[k*DATA_W +: DATA_W] = rd_val;
            assign rbusy[k]                  = busy[rd_addr] && !(hit0 || hit1);
        end
    endgenerate

endmodule

// File: tb/tb_grf_multiport.sv
// tb/tb_grf_multiport.sv - self-checking bench for grf_multiport, bypass and non-bypass builds
module tb_grf_multiport;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             we0, we1, issue_valid;
    logic [AW-1:0]    waddr0, waddr1, issue_addr;
    logic [DW-1:0]    wdata0, wdata1;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata_b, rdata_n;
    logic [NR-1:0]    rbusy_b, rbusy_n;
    logic             busy_any_b, busy_any_n;

    logic [DW-1:0]    m_reg  [DEPTH];
    bit               m_busy [DEPTH];
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    grf_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .busy_any(busy_any_b)
    );

    grf_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .busy_any(busy_any_n)
    );

    // Reference: architectural register/busy state plus the forwarding rule applied to live inputs.
    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (reset || a == 0) return '0;
        if (byp && we1 && waddr1 == a) return wdata1;
        if (byp && we0 && waddr0 == a) return wdata0;
        return m_reg[a];
    endfunction

    function automatic bit exp_bz(input logic [AW-1:0] a, input bit byp);
        if (reset || a == 0) return 1'b0;
        if (byp && ((we1 && waddr1 == a) || (we0 && waddr0 == a))) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic bit exp_any();
        if (reset) return 1'b0;
        foreach (m_busy[i]) if (m_busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    task automatic idle();
        we0 = 0; we1 = 0; issue_valid = 0;
        waddr0 = '0; waddr1 = '0; issue_addr = '0;
        wdata0 = '0; wdata1 = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            if (we0 && waddr0 != 0) m_reg[waddr0] = wdata0;
            if (we1 && waddr1 != 0) m_reg[waddr1] = wdata1;
            if (we0) m_busy[waddr0] = 1'b0;
            if (we1) m_busy[waddr1] = 1'b0;
            if (issue_valid && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        we0 = 1; waddr0 = 5; wdata0 = 32'h1111; issue_valid = 1; issue_addr = 6;
        tick();
        idle();
        raddr = {AW'(6), AW'(5)};
        #1;
        checks += 2;
        if (rdata_b[0 +: DW] !== 32'h1111) begin
            errors++; $display("FAIL preload_rdata: got %h expected %h", rdata_b[0 +: DW], 32'h1111);
        end
        if (rbusy_b[1] !== 1'b1) begin
            errors++; $display("FAIL preload_rbusy: got %b expected 1", rbusy_b[1]);
        end
        #1 reset = 1; model_clear();
        #1;
        checks += 4;
        if (rdata_b[0 +: DW] !== '0 || rdata_n[0 +: DW] !== '0) begin
            errors++; $display("FAIL reset_async_rdata: got %h/%h expected 0", rdata_b[0 +: DW], rdata_n[0 +: DW]);
        end
        if (rbusy_b !== '0 || rbusy_n !== '0) begin
            errors++; $display("FAIL reset_async_rbusy: got %b/%b expected 0", rbusy_b, rbusy_n);
        end
        if (busy_any_b !== 1'b0 || busy_any_n !== 1'b0) begin
            errors++; $display("FAIL reset_async_busy_any: got %b/%b expected 0", busy_any_b, busy_any_n);
        end
        we0 = 1; waddr0 = 5; wdata0 = 32'hDEAD; issue_valid = 1; issue_addr = 6;
        #1;
        if (rdata_b[0 +: DW] !== '0) begin
            errors++; $display("FAIL reset_no_bypass: got %h expected 0", rdata_b[0 +: DW]);
        end
        tick();
        idle();
        reset = 0;
        #1;
        checks += 2;
        if (rdata_b[0 +: DW] !== '0 || rdata_n[0 +: DW] !== '0) begin
            errors++; $display("FAIL reset_write_ignored: got %h/%h expected 0", rdata_b[0 +: DW], rdata_n[0 +: DW]);
        end
        if (busy_any_b !== 1'b0 || rbusy_b[1] !== 1'b0) begin
            errors++; $display("FAIL reset_issue_ignored: got any=%b rbusy=%b expected 0", busy_any_b, rbusy_b[1]);
        end
    endtask

    task automatic test_bypass();
        idle();
        we0 = 1; waddr0 = 5; wdata0 = 32'h1234;
        raddr[0 +: AW] = 5;
        #1;
        checks += 2;
        if (rdata_b[0 +: DW] !== 32'h1234) begin
            errors++; $display("FAIL bypass_same_cycle: got %h expected %h", rdata_b[0 +: DW], 32'h1234);
        end
        if (rdata_n[0 +: DW] !== 32'h0) begin
            errors++; $display("FAIL nobypass_same_cycle: got %h expected 0", rdata_n[0 +: DW]);
        end
        tick();
        idle();
        #1;
        checks += 1;
        if (rdata_n[0 +: DW] !== 32'h1234 || rdata_b[0 +: DW] !== 32'h1234) begin
            errors++; $display("FAIL write_next_cycle: got %h/%h expected %h", rdata_b[0 +: DW], rdata_n[0 +: DW], 32'h1234);
        end
    endtask

    task automatic test_collision();
        idle();
        we0 = 1; waddr0 = 7; wdata0 = 32'hAAAA;
        we1 = 1; waddr1 = 7; wdata1 = 32'h5555;
        raddr[AW +: AW] = 7;
        #1;
        checks += 2;
        if (rdata_b[DW +: DW] !== 32'h5555) begin
            errors++; $display("FAIL collision_bypass: got %h expected %h", rdata_b[DW +: DW], 32'h5555);
        end
        if (rdata_n[DW +: DW] !== 32'h0) begin
            errors++; $display("FAIL collision_nobypass_old: got %h expected 0", rdata_n[DW +: DW]);
        end
        tick();
        idle();
        #1;
        checks += 1;
        if (rdata_b[DW +: DW] !== 32'h5555 || rdata_n[DW +: DW] !== 32'h5555) begin
            errors++; $display("FAIL collision_stored: got %h/%h expected %h", rdata_b[DW +: DW], rdata_n[DW +: DW], 32'h5555);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        we0 = 1; waddr0 = 0; wdata0 = 32'hFFFF_FFFF;
        we1 = 1; waddr1 = 0; wdata1 = 32'hFFFF_FFFF;
        issue_valid = 1; issue_addr = 0;
        raddr[0 +: AW] = 0;
        #1;
        checks += 1;
        if (rdata_b[0 +: DW] !== '0) begin
            errors++; $display("FAIL zero_reg_bypass: got %h expected 0", rdata_b[0 +: DW]);
        end
        tick();
        idle();
        #1;
        checks += 3;
        if (rdata_b[0 +: DW] !== '0 || rdata_n[0 +: DW] !== '0) begin
            errors++; $display("FAIL zero_reg_stored: got %h/%h expected 0", rdata_b[0 +: DW], rdata_n[0 +: DW]);
        end
        if (busy_any_b !== 1'b0 || busy_any_n !== 1'b0) begin
            errors++; $display("FAIL zero_reg_busy_any: got %b/%b expected 0", busy_any_b, busy_any_n);
        end
        if (rbusy_b[0] !== 1'b0) begin
            errors++; $display("FAIL zero_reg_rbusy: got %b expected 0", rbusy_b[0]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        issue_valid = 1; issue_addr = 3;
        raddr[0 +: AW] = 3;
        #1;
        checks += 1;
        if (rbusy_b[0] !== 1'b0 || rbusy_n[0] !== 1'b0) begin
            errors++; $display("FAIL issue_same_cycle: got %b/%b expected 0", rbusy_b[0], rbusy_n[0]);
        end
        tick();
        idle();
        #1;
        checks += 2;
        if (rbusy_b[0] !== 1'b1 || rbusy_n[0] !== 1'b1) begin
            errors++; $display("FAIL issue_next_cycle: got %b/%b expected 1", rbusy_b[0], rbusy_n[0]);
        end
        if (busy_any_b !== 1'b1) begin
            errors++; $display("FAIL issue_busy_any: got %b expected 1", busy_any_b);
        end
        we0 = 1; waddr0 = 3; wdata0 = 32'h0ABC;
        #1;
        checks += 2;
        if (rbusy_b[0] !== 1'b0) begin
            errors++; $display("FAIL writeback_bypass_rbusy: got %b expected 0", rbusy_b[0]);
        end
        if (rbusy_n[0] !== 1'b1) begin
            errors++; $display("FAIL writeback_nobypass_rbusy: got %b expected 1", rbusy_n[0]);
        end
        tick();
        idle();
        #1;
        checks += 1;
        if (rbusy_b[0] !== 1'b0 || rbusy_n[0] !== 1'b0 || busy_any_n !== 1'b0) begin
            errors++; $display("FAIL writeback_cleared: got %b/%b any=%b expected 0", rbusy_b[0], rbusy_n[0], busy_any_n);
        end
    endtask

    task automatic test_issue_write_same();
        idle();
        issue_valid = 1; issue_addr = 9;
        we1 = 1; waddr1 = 9; wdata1 = 32'h0000_0099;
        raddr[AW +: AW] = 9;
        #1;
        checks += 1;
        if (rbusy_b[1] !== 1'b0 || rdata_b[DW +: DW] !== 32'h99) begin
            errors++; $display("FAIL issue_write_fwd: got busy=%b data=%h expected 0/%h", rbusy_b[1], rdata_b[DW +: DW], 32'h99);
        end
        tick();
        idle();
        #1;
        checks += 2;
        if (rbusy_b[1] !== 1'b1 || rbusy_n[1] !== 1'b1) begin
            errors++; $display("FAIL issue_write_busy: got %b/%b expected 1", rbusy_b[1], rbusy_n[1]);
        end
        if (rdata_n[DW +: DW] !== 32'h99) begin
            errors++; $display("FAIL issue_write_data: got %h expected %h", rdata_n[DW +: DW], 32'h99);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            we0 = ($urandom_range(0, 1) == 1); waddr0 = rnd_addr(); wdata0 = $urandom;
            we1 = ($urandom_range(0, 1) == 1); waddr1 = rnd_addr(); wdata1 = $urandom;
            issue_valid = ($urandom_range(0, 4) < 2); issue_addr = rnd_addr();
            for (int k = 0; k < NR; k++) raddr[k*AW +: AW] = rnd_addr();
            #1;
            for (int k = 0; k < NR; k++) begin
                logic [AW-1:0] a;
                a = raddr[k*AW +: AW];
                checks += 4;
                if (rdata_b[k*DW +: DW] !== exp_rd(a, 1'b1)) begin
                    errors++; $display("FAIL rand_rdata_bypass c=%0d port=%0d addr=%0d: got %h expected %h", c, k, a, rdata_b[k*DW +: DW], exp_rd(a, 1'b1));
                end
                if (rdata_n[k*DW +: DW] !== exp_rd(a, 1'b0)) begin
                    errors++; $display("FAIL rand_rdata_nobypass c=%0d port=%0d addr=%0d: got %h expected %h", c, k, a, rdata_n[k*DW +: DW], exp_rd(a, 1'b0));
                end
                if (rbusy_b[k] !== exp_bz(a, 1'b1)) begin
                    errors++; $display("FAIL rand_rbusy_bypass c=%0d port=%0d addr=%0d: got %b expected %b", c, k, a, rbusy_b[k], exp_bz(a, 1'b1));
                end
                if (rbusy_n[k] !== exp_bz(a, 1'b0)) begin
                    errors++; $display("FAIL rand_rbusy_nobypass c=%0d port=%0d addr=%0d: got %b expected %b", c, k, a, rbusy_n[k], exp_bz(a, 1'b0));
                end
            end
            checks += 1;
            if (busy_any_b !== exp_any() || busy_any_n !== exp_any()) begin
                errors++; $display("FAIL rand_busy_any c=%0d: got %b/%b expected %b", c, busy_any_b, busy_any_n, exp_any());
            end
            tick();
        end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 20; c++) begin
            we0 = 1; waddr0 = AW'($urandom_range(1, DEPTH - 1)); wdata0 = $urandom | 32'h1;
            we1 = 1; waddr1 = AW'($urandom_range(1, DEPTH - 1)); wdata1 = $urandom | 32'h1;
            issue_valid = 1; issue_addr = AW'($urandom_range(1, DEPTH - 1));
            tick();
        end
        #2 reset = 1; model_clear();
        for (int a = 0; a < DEPTH; a++) begin
            raddr = {AW'(a), AW'(a)};
            #1;
            checks += 2;
            if (rdata_b !== '0 || rdata_n !== '0) begin
                errors++; $display("FAIL midburst_reset_rdata addr=%0d: got %h/%h expected 0", a, rdata_b, rdata_n);
            end
            if (rbusy_b !== '0 || rbusy_n !== '0 || busy_any_b !== 1'b0 || busy_any_n !== 1'b0) begin
                errors++; $display("FAIL midburst_reset_busy addr=%0d: got %b/%b any=%b/%b expected 0", a, rbusy_b, rbusy_n, busy_any_b, busy_any_n);
            end
        end
        @(negedge clk);
        idle();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        idle();
        raddr = '0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 0;
        test_reset();
        test_bypass();
        test_collision();
        test_zero_reg();
        test_scoreboard();
        test_issue_write_same();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
